// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// Owns the architectural HI/LO registers. Raises a stall towards the hazard
// unit while an operation is in flight, and accepts MTHI/MTLO writes while idle.
//
// Each operation runs WIDTH iterations on one shared adder:
//   - multiply: shift-add
//   - divide:   restoring subtract
// A sign-correction cycle follows the iterations, then a one-cycle DONE pulse.
//
// Optional build macro MULDIV_EARLY_EXIT_EN: multiplies leave CALC as soon as
// the remaining multiplier bits are all zero. Divides are unaffected.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_SIGN = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Two's-complement negation of one operand-wide word.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    neg_w = ~v + WIDTH'(1);
  endfunction

  // Two's-complement negation of a full double-width product.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    neg_2w = ~v + (2*WIDTH)'(1);
  endfunction

  // Control state (reset)
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  // Datapath state (no reset; always loaded when an operation is accepted)
  //   acc_hi: partial product upper half, or partial remainder
  //   acc_lo: multiplier/product lower half, or dividend/quotient
  //   opnd  : multiplicand (|a|), or divisor (|b|)
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;

  // Operand preparation for the accept cycle
  logic             op_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             b_zero;
  logic             accept;

  assign op_signed = ~op[0];
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign a_abs     = a_neg ? neg_w(a) : a;
  assign b_abs     = b_neg ? neg_w(b) : b;
  assign b_zero    = (b == '0);
  assign accept    = (state_q == S_IDLE) & start & ~flush;

  // The single shared adder.
  // Two extra bits: one holds the multiply carry, one holds the divide borrow.
  logic [WIDTH+1:0] add_a, add_b, add_sum;
  logic             add_cin;
  logic             div_ok;

  // Adder operand select: add the multiplicand, or subtract the divisor
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (is_div_q) begin
      add_a   = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1]};
      add_b   = ~{2'b00, opnd_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {2'b00, acc_hi_q};
      add_b   = acc_lo_q[0] ? {2'b00, opnd_q} : '0;
      add_cin = 1'b0;
    end
  end

  assign add_sum = add_a + add_b + {{(WIDTH+1){1'b0}}, add_cin};

  // Restoring divide: the trial subtraction is kept only if it did not borrow.
  assign div_ok  = ~add_sum[WIDTH+1];

  // Early-exit detection and product alignment
  logic                 calc_skip;
  logic [2*WIDTH-1:0]   prod_raw;
`ifdef MULDIV_EARLY_EXIT_EN
  logic [CNT_W:0]       pp_shamt;
  // After cnt iterations, the low WIDTH-cnt bits of acc_lo still hold the
  // unconsumed multiplier.
  assign calc_skip = ~is_div_q & ((acc_lo_q << cnt_q) == '0);
  // Each skipped iteration would only have shifted right, so apply that
  // shift in one step here.
  assign pp_shamt  = (CNT_W+1)'(WIDTH) - {1'b0, cnt_q};
  assign prod_raw  = {acc_hi_q, acc_lo_q} >> pp_shamt;
`else
  assign calc_skip = 1'b0;
  assign prod_raw  = {acc_hi_q, acc_lo_q};
`endif

  // Sign correction applied in SIGN and written to HI/LO on the way to DONE
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign prod_fix = neg_res_q ? neg_2w(prod_raw) : prod_raw;
  assign quo_fix  = neg_res_q ? neg_w(acc_lo_q) : acc_lo_q;
  assign rem_fix  = neg_rem_q ? neg_w(acc_hi_q) : acc_hi_q;
  assign res_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

  // Next-state, counter, HI/LO and div_zero update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (accept) begin
          cnt_d = '0;
          dz_d  = 1'b0;
          if (op[1] && b_zero) begin
            // A zero divisor needs no iterations: report directly.
            hi_d    = a;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (calc_skip) begin
          state_d = S_SIGN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  // Datapath next value: load operands on accept, iterate once per CALC cycle
  always_comb begin
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    if (accept) begin
      is_div_d  = op[1];
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      acc_hi_d  = '0;
      opnd_d    = op[1] ? b_abs : a_abs;
      acc_lo_d  = op[1] ? a_abs : b_abs;
    end else if ((state_q == S_CALC) && !calc_skip) begin
      if (is_div_q) begin
        acc_hi_d = div_ok ? add_sum[WIDTH-1:0]
                          : {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
      end else begin
        acc_hi_d = add_sum[WIDTH:1];
        acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
      end
    end
  end

  // Datapath registers, no reset
  always_ff @(posedge clk) begin
    acc_hi_q  <= acc_hi_d;
    acc_lo_q  <= acc_lo_d;
    opnd_q    <= opnd_d;
    is_div_q  <= is_div_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign stall    = (start & (state_q == S_IDLE) & ~flush)
                  | (state_q == S_CALC) | (state_q == S_SIGN);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_muldiv_seq;

`ifdef MULDIV_EARLY_EXIT_EN
  localparam int LAT_M7  = 6;   // |b|=7: 3 significant bits + 1 CALC, then SIGN, DONE
  localparam int LAT_M3  = 5;   // |b|=3
  localparam int FLUSH_K = 3;   // still inside CALC for b=3
`else
  localparam int LAT_M7  = 34;
  localparam int LAT_M3  = 34;
  localparam int FLUSH_K = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic [31:0] hi, lo;
  logic        busy, stall, done, div_zero;

  int errors = 0;
  int checks = 0;

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Issues one operation and waits for done.
  // Cycle T is k=0; done_at is the k at which done was seen (-1 if never).
  // stall_bad counts cycles where stall was not high before done, or not low at done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int done_at, output int stall_bad);
    done_at   = -1;
    stall_bad = 0;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    #1;
    if (stall !== 1'b1) stall_bad++;
    for (int k = 1; k <= 60 && done_at < 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done === 1'b1) begin
        done_at = k;
        if (stall !== 1'b0) stall_bad++;
      end else if (stall !== 1'b1) begin
        stall_bad++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h want=%h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h want=%h", lo, 32'h0); end
    checks++; if ({busy, stall, done, div_zero} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags got=%b want=0000", {busy, stall, done, div_zero}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%b want=0", busy); end
  endtask

  task automatic test_mult_signed();
    int d, sb;
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, d, sb);
    checks++; if (d !== LAT_M7) begin errors++; $display("FAIL mult_latency got=%0d want=%0d", d, LAT_M7); end
    checks++; if (sb !== 0) begin errors++; $display("FAIL mult_stall bad_cycles=%0d want=0", sb); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h want=%h", hi, 32'hFFFFFFFF); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got=%h want=%h", lo, 32'hFFFFFFEB); end
    @(negedge clk);
    #1;
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL mult_done_pulse got=%b want=00", {done, busy}); end
  endtask

  task automatic test_multu();
    int d, sb;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, d, sb);
    checks++; if (d !== 34) begin errors++; $display("FAIL multu_latency got=%0d want=34", d); end
    checks++; if (sb !== 0) begin errors++; $display("FAIL multu_stall bad_cycles=%0d want=0", sb); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got=%h want=%h", hi, 32'hFFFFFFFE); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got=%h want=%h", lo, 32'h00000001); end
  endtask

  task automatic test_div_signed();
    int d, sb;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, d, sb);
    checks++; if (d !== 34) begin errors++; $display("FAIL div_latency got=%0d want=34", d); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_quot got=%h want=%h", lo, 32'hFFFFFFFD); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_rem got=%h want=%h", hi, 32'hFFFFFFFF); end
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, d, sb);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_quot got=%h want=%h", lo, 32'h80000000); end
    checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL div_ovf_rem got=%h want=%h", hi, 32'h0); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_ovf_dz got=%b want=0", div_zero); end
  endtask

  task automatic test_div_zero();
    int d, sb;
    run_op(2'b11, 32'd100, 32'd0, d, sb);
    checks++; if (d !== 1) begin errors++; $display("FAIL dz_latency got=%0d want=1", d); end
    checks++; if (sb !== 0) begin errors++; $display("FAIL dz_stall bad_cycles=%0d want=0", sb); end
    checks++; if (hi !== 32'h00000064) begin errors++; $display("FAIL dz_hi got=%h want=%h", hi, 32'h64); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_lo got=%h want=%h", lo, 32'hFFFFFFFF); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b want=1", div_zero); end
    // The next accepted start clears the sticky flag.
    run_op(2'b11, 32'd100, 32'd7, d, sb);
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got=%b want=0", div_zero); end
    checks++; if (d !== 34) begin errors++; $display("FAIL divu_latency got=%0d want=34", d); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_rem got=%h want=%h", hi, 32'd2); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_quot got=%h want=%h", lo, 32'd14); end
  endtask

  task automatic test_flush();
    int done_seen;
    // Give HI/LO known values with MTHI/MTLO while idle.
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b0; wdata = 32'h11111111;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22222222;
    @(negedge clk);
    lo_we = 1'b0;
    #1;
    checks++; if (hi !== 32'h11111111) begin errors++; $display("FAIL mthi got=%h want=%h", hi, 32'h11111111); end
    checks++; if (lo !== 32'h22222222) begin errors++; $display("FAIL mtlo got=%h want=%h", lo, 32'h22222222); end
    // flush together with start in IDLE: the start is dropped.
    @(negedge clk);
    op = 2'b01; a = 32'd5; b = 32'd3; start = 1'b1; flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_start_stall got=%b want=0", stall); end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy got=%b want=0", busy); end
    // MULTU 5*3, flushed at T+FLUSH_K.
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= FLUSH_K; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == FLUSH_K) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b want=0", busy); end
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL flush_no_done pulses=%0d want=0", done_seen); end
    checks++; if (hi !== 32'h11111111) begin errors++; $display("FAIL flush_hi got=%h want=%h", hi, 32'h11111111); end
    checks++; if (lo !== 32'h22222222) begin errors++; $display("FAIL flush_lo got=%h want=%h", lo, 32'h22222222); end
  endtask

  task automatic test_back_to_back();
    int d;
    // MTHI/MTLO in the same cycle as an accepted start are honoured.
    @(negedge clk);
    op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    #1;
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL same_cycle_mthi got=%h want=%h", hi, 32'h12345678); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL same_cycle_busy got=%b want=1", busy); end
    d = (done === 1'b1) ? 1 : -1;
    for (int k = 2; k <= 60 && d < 0; k++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) d = k;
    end
    checks++; if (d !== LAT_M3) begin errors++; $display("FAIL same_cycle_latency got=%0d want=%0d", d, LAT_M3); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL same_cycle_hi got=%h want=%h", hi, 32'd0); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL same_cycle_lo got=%h want=%h", lo, 32'd6); end
  endtask

  task automatic test_busy_and_reset();
    int busy_bad;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hAAAA0000;
    @(negedge clk);
    hi_we = 1'b0;
    // MULTU with a 32-bit multiplier, start held high for the whole op.
    op = 2'b01; a = 32'd9; b = 32'h80000001; start = 1'b1;
    busy_bad = 0;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      if (k == 5) begin hi_we = 1'b1; wdata = 32'h55555555; end
      if (k == 6) begin
        hi_we = 1'b0;
        #1;
        checks++; if (hi !== 32'hAAAA0000) begin errors++; $display("FAIL busy_mthi_ignored got=%h want=%h", hi, 32'hAAAA0000); end
      end
      #1;
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
    end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL busy_hold bad_cycles=%0d want=0", busy_bad); end
    // Asynchronous reset in the middle of cycle T+20.
    @(negedge clk);
    #2;
    rst_n = 1'b0; start = 1'b0;
    #1;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL async_rst_hi got=%h want=%h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL async_rst_lo got=%h want=%h", lo, 32'h0); end
    checks++; if ({busy, stall, done, div_zero} !== 4'b0000)
      begin errors++; $display("FAIL async_rst_flags got=%b want=0000", {busy, stall, done, div_zero}); end
    busy_bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) busy_bad++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) busy_bad++;
    end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL async_rst_no_done bad_cycles=%0d want=0", busy_bad); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    test_reset();
    test_mult_signed();
    test_multu();
    test_div_signed();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_busy_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the EX stage, beside the single-cycle ALU.
- Runs a 32-iteration shift-add multiply or restoring divide on one internal adder, with sign correction, and holds the HI/LO architectural registers.
- Drives a stall to the hazard unit while an operation is in flight.
- Accepts MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH bits each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request an operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- flush  input  1  synchronous abort from branch/exception logic.
- hi_we, lo_we  input  1 each  MTHI/MTLO write enables.
- wdata  input  WIDTH  MTHI/MTLO data.
- hi, lo  output  WIDTH  architectural HI/LO registers.
- busy  output  1  high in any state except IDLE.
- stall  output  1  combinational: (start & IDLE & ~flush) | CALC | SIGN.
- done  output  1  one-cycle pulse in DONE state.
- div_zero  output  1  sticky flag, set by a divide with b==0, cleared by the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=lo=0, busy=stall=done=div_zero=0, counter=0.
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - start & ~flush in cycle T latches |a|, |b|, sign info and op, then enters CALC at T+1.
  - Signed ops take absolute values.
  - Unsigned ops use raw operands.
- Divide with b==0:
  - Skips CALC and enters DONE at T+1.
  - hi=a, lo=all ones, div_zero=1.
- CALC: runs exactly WIDTH cycles (T+1..T+32), counter 0..WIDTH-1, then enters SIGN.
  - Multiply: 2*WIDTH product accumulator, one shift-add per cycle.
  - Divide: one restoring subtract per cycle, quotient bit shifted in.
- SIGN (T+33):
  - Negates the product if the operand signs differ (signed mult).
  - Negates the quotient if the operand signs differ, and negates the remainder if the dividend is negative (signed div).
  - Writes hi/lo on the SIGN->DONE edge.
  - hi/lo mapping: mult gives hi=upper half, lo=lower half; div gives hi=remainder, lo=quotient.
- DONE (T+34): done=1, stall=0, then returns to IDLE.
- Signed 0x80000000 / -1: lo=0x80000000, hi=0. No trap.
- start while busy: ignored.
- flush:
  - In any non-IDLE state, returns to IDLE on the next edge.
  - No done pulse, hi/lo unchanged.
  - flush and start together in IDLE: the start is ignored.
- hi_we/lo_we:
  - Honoured only in IDLE, including the same cycle as an accepted start.
  - Ignored while busy.
- Reset mid-operation: immediate return to the reset values; the in-flight result is lost.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined:
  - For MULT/MULTU, CALC checks the remaining (right-shifted) multiplier at the start of each cycle.
  - If it is zero, that cycle does no work and the next state is SIGN.
  - Latency becomes (significant bits of |b|)+1 CALC cycles; b=3 gives done at T+5, b=0 gives done at T+3.
  - Divide latency is unchanged.
- Undefined: CALC always runs WIDTH cycles for every op.

Test Plan:
- MULT a=0xFFFFFFFD, b=7 -> stall high T..T+33; done at T+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done at T+34 (T+34 also with early exit).
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> done at T+1; hi=0x64, lo=0xFFFFFFFF, div_zero=1; the next start clears div_zero.
- MULTU 5*3 with flush at T+10 -> busy low at T+11; no done; hi/lo keep their prior values.
- start held high during an op; hi_we at T+5; rst_n low at T+20 -> second start ignored; HI not written; all outputs reset asynchronously with no done pulse.
